// File: rtl/bdcmotor_pkg.sv
// Shared constants and types for the SPI register interface of the motor controller.
// Register map addresses, frame geometry and the frame FSM encoding live here.
package bdcmotor_pkg;

    localparam int FRAME_W  = 16;
    localparam int CMD_BITS = 8;
    localparam int CNT_W    = 5;

    localparam logic [2:0] ADDR_CFG     = 3'd0;
    localparam logic [2:0] ADDR_CTRL    = 3'd1;
    localparam logic [2:0] ADDR_WDOGDIV = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    // Readback mux; unmapped addresses read as zero.
    function automatic logic [7:0] rd_select(input logic [2:0] addr,
                                             input logic [7:0] cfg,
                                             input logic [7:0] ctrl,
                                             input logic [7:0] wdogdiv);
        logic [7:0] val;
        val = 8'h00;
        case (addr)
            ADDR_CFG:     val = cfg;
            ADDR_CTRL:    val = ctrl;
            ADDR_WDOGDIV: val = wdogdiv;
            default:      val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Resettable multi-flop bit synchronizer for an asynchronous input.
// RSTVAL is the idle level of the input so no edge is seen when reset releases.
module spi_sync #(
    parameter int   STAGES = 2,
    parameter logic RSTVAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr <= {STAGES{RSTVAL}};
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_regif.sv
// SPI mode-0 slave decoding 16-bit frames into register write strobes and readback.
// Frame: rw, 4 ignored bits, 3-bit address, 8-bit data, all sampled on the clk domain.
module spi_regif
    import bdcmotor_pkg::*;
#(
    parameter int SYNCSTAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sck,
    input  logic       csn,
    input  logic       mosi,
    output logic       miso,
    output logic       misooe,
    output logic [7:0] wrtdata,
    output logic       cfgld,
    output logic       ctrlld,
    output logic       wdogdivld,
    output logic       ctrlrdce,
    input  logic [7:0] cfgrd,
    input  logic [7:0] ctrlrd,
    input  logic [7:0] wdogdivrd,
    output logic [1:0] dbgstate
);

    logic sck_s, csn_s, mosi_s;
    logic sck_d, csn_d;
    logic sck_rise, sck_fall, csn_fall;

    spi_sync #(.STAGES(SYNCSTAGES), .RSTVAL(1'b0)) u_sync_sck (
        .clk (clk), .rstn(rstn), .d(sck), .q(sck_s)
    );
    spi_sync #(.STAGES(SYNCSTAGES), .RSTVAL(1'b1)) u_sync_csn (
        .clk (clk), .rstn(rstn), .d(csn), .q(csn_s)
    );
    spi_sync #(.STAGES(SYNCSTAGES), .RSTVAL(1'b0)) u_sync_mosi (
        .clk (clk), .rstn(rstn), .d(mosi), .q(mosi_s)
    );

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign csn_fall = ~csn_s & csn_d;

    spi_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       rx_sr, rx_nxt, rx_shift;
    logic [7:0]       tx_sr, tx_nxt;
    logic             rw_q, rw_nxt;
    logic [2:0]       addr_q, addr_nxt;
    logic [7:0]       wrt_nxt;
    logic             cfg_nxt, ctrl_nxt, wdog_nxt, rdce_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_d     <= 1'b0;
            csn_d     <= 1'b1;
            state     <= ST_IDLE;
            cnt       <= '0;
            rx_sr     <= 8'h00;
            tx_sr     <= 8'h00;
            rw_q      <= 1'b0;
            addr_q    <= 3'd0;
            wrtdata   <= 8'h00;
            cfgld     <= 1'b0;
            ctrlld    <= 1'b0;
            wdogdivld <= 1'b0;
            ctrlrdce  <= 1'b0;
        end else begin
            sck_d     <= sck_s;
            csn_d     <= csn_s;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rx_sr     <= rx_nxt;
            tx_sr     <= tx_nxt;
            rw_q      <= rw_nxt;
            addr_q    <= addr_nxt;
            wrtdata   <= wrt_nxt;
            cfgld     <= cfg_nxt;
            ctrlld    <= ctrl_nxt;
            wdogdivld <= wdog_nxt;
            ctrlrdce  <= rdce_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rx_nxt    = rx_sr;
        tx_nxt    = tx_sr;
        rw_nxt    = rw_q;
        addr_nxt  = addr_q;
        wrt_nxt   = wrtdata;
        cfg_nxt   = 1'b0;
        ctrl_nxt  = 1'b0;
        wdog_nxt  = 1'b0;
        rdce_nxt  = 1'b0;
        rx_shift  = {rx_sr[6:0], mosi_s};

        // A new csn falling edge always restarts the frame, whatever state we are in.
        if (csn_fall) begin
            state_nxt = ST_CMD;
            cnt_nxt   = '0;
        end else if (csn_s) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_CMD: begin
                    if (sck_rise) begin
                        rx_nxt  = rx_shift;
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == CNT_W'(CMD_BITS - 1)) begin
                            state_nxt = ST_DATA;
                            rw_nxt    = rx_shift[7];
                            addr_nxt  = rx_shift[2:0];
                            tx_nxt    = rx_shift[7] ?
                                        rd_select(rx_shift[2:0], cfgrd, ctrlrd, wdogdivrd) :
                                        8'h00;
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_rise) begin
                        rx_nxt  = rx_shift;
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == CNT_W'(FRAME_W - 1)) begin
                            state_nxt = ST_DONE;
                            if (rw_q) begin
                                rdce_nxt = (addr_q == ADDR_CTRL);
                            end else begin
                                case (addr_q)
                                    ADDR_CFG: begin
                                        cfg_nxt = 1'b1;
                                        wrt_nxt = rx_shift;
                                    end
                                    ADDR_CTRL: begin
                                        ctrl_nxt = 1'b1;
                                        wrt_nxt  = rx_shift;
                                    end
                                    ADDR_WDOGDIV: begin
                                        wdog_nxt = 1'b1;
                                        wrt_nxt  = rx_shift;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    // The falling edge right after the command byte keeps the MSB on miso
                    // so the host samples it on the first data rising edge.
                    end else if (sck_fall && cnt != CNT_W'(CMD_BITS)) begin
                        tx_nxt = {tx_sr[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign miso     = (state == ST_DATA) & tx_sr[7];
    assign misooe   = ~csn_s;
    assign dbgstate = state;

endmodule

// File: tb/tb_spi_regif.sv
// Self-checking bench for spi_regif: drives SPI mode-0 frames and scoreboards the
// register strobes against expected events queued as each frame is issued.
module tb_spi_regif;
    import bdcmotor_pkg::*;

    localparam int HALF = 6;
    localparam logic [2:0] K_CFG  = 3'd0;
    localparam logic [2:0] K_CTRL = 3'd1;
    localparam logic [2:0] K_WDOG = 3'd2;
    localparam logic [2:0] K_RDCE = 3'd3;

    logic       clk = 1'b0;
    logic       rstn, sck, csn, mosi;
    logic       miso, misooe;
    logic [7:0] wrtdata;
    logic       cfgld, ctrlld, wdogdivld, ctrlrdce;
    logic [7:0] cfgrd, ctrlrd, wdogdivrd;
    logic [1:0] dbgstate;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    logic        multi_hot = 1'b0;

    spi_regif #(.SYNCSTAGES(2)) dut (
        .clk(clk), .rstn(rstn), .sck(sck), .csn(csn), .mosi(mosi),
        .miso(miso), .misooe(misooe), .wrtdata(wrtdata),
        .cfgld(cfgld), .ctrlld(ctrlld), .wdogdivld(wdogdivld), .ctrlrdce(ctrlrdce),
        .cfgrd(cfgrd), .ctrlrd(ctrlrd), .wdogdivrd(wdogdivrd), .dbgstate(dbgstate)
    );

    always #5 clk = ~clk;

    // Strobe monitor: every cycle a strobe is high becomes one observed event.
    always @(negedge clk) begin
        if (rstn) begin
            if ((32'(cfgld) + 32'(ctrlld) + 32'(wdogdivld) + 32'(ctrlrdce)) > 1)
                multi_hot = 1'b1;
            if (cfgld)     obs_q.push_back({K_CFG, wrtdata});
            if (ctrlld)    obs_q.push_back({K_CTRL, wrtdata});
            if (wdogdivld) obs_q.push_back({K_WDOG, wrtdata});
            if (ctrlrdce)  obs_q.push_back({K_RDCE, wrtdata});
        end
    end

    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        repeat (HALF) @(negedge clk);
        m   = miso;
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] w, input int nbits,
                             output logic [7:0] rd, output logic oe_ok);
        logic [15:0] sh;
        logic        m;
        sh    = w;
        rd    = 8'h00;
        oe_ok = 1'b1;
        csn   = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            send_bit(sh[15], m);
            sh = {sh[14:0], 1'b1};
            if (i >= 8 && i < 16) rd = {rd[6:0], m};
            if (misooe !== 1'b1) oe_ok = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        csn = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic drain_scoreboard(input string tag);
        logic [10:0] e, o;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s event_count got %0d want %0d", tag, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 11'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s event got %h want %h", tag, o, e);
            end
        end
        obs_q.delete();
        checks++;
        if (multi_hot !== 1'b0) begin
            errors++;
            $display("FAIL %s onehot got multiple strobes want at most one", tag);
        end
        multi_hot = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sck = 1'b0; csn = 1'b1; mosi = 1'b0;
        cfgrd = 8'h00; ctrlrd = 8'h00; wdogdivrd = 8'h00;
        repeat (4) @(negedge clk);
        checks++;
        if ({miso, misooe, wrtdata, cfgld, ctrlld, wdogdivld, ctrlrdce} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                     {miso, misooe, wrtdata, cfgld, ctrlld, wdogdivld, ctrlrdce});
        end
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (dbgstate !== 2'(ST_IDLE) || misooe !== 1'b0 || wrtdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_release state %0d oe %b wrtdata %h want 0 0 00",
                     dbgstate, misooe, wrtdata);
        end
        drain_scoreboard("reset_no_strobe");
    endtask

    task automatic test_cfg_write();
        logic [7:0] rd;
        logic       oe;
        exp_q.push_back({K_CFG, 8'h25});
        run_frame(16'h0025, 16, rd, oe);
        checks++;
        if (oe !== 1'b1) begin
            errors++;
            $display("FAIL cfg_write misooe got low during frame want high");
        end
        checks++;
        if (wrtdata !== 8'h25) begin
            errors++;
            $display("FAIL cfg_write wrtdata got %h want 25", wrtdata);
        end
        drain_scoreboard("cfg_write");
    endtask

    task automatic test_readback();
        logic [7:0] rd, c0, c2;
        logic       oe;
        ctrlrd = 8'h88;
        exp_q.push_back({K_RDCE, 8'h25});
        run_frame(16'h8100, 16, rd, oe);
        checks++;
        if (rd !== 8'h88) begin
            errors++;
            $display("FAIL read_ctrl miso got %h want 88", rd);
        end
        drain_scoreboard("read_ctrl");
        c0 = 8'($urandom_range(1, 255));
        c2 = 8'($urandom_range(1, 255));
        cfgrd = c0;
        wdogdivrd = c2;
        run_frame(16'h8000, 16, rd, oe);
        checks++;
        if (rd !== c0) begin
            errors++;
            $display("FAIL read_cfg miso got %h want %h", rd, c0);
        end
        run_frame(16'hF200, 16, rd, oe);
        checks++;
        if (rd !== c2) begin
            errors++;
            $display("FAIL read_wdog miso got %h want %h", rd, c2);
        end
        drain_scoreboard("read_no_rdce");
    endtask

    task automatic test_abort();
        logic [7:0] rd;
        logic       oe;
        run_frame(16'h0233, 12, rd, oe);
        checks++;
        if (wrtdata !== 8'h25 || dbgstate !== 2'(ST_IDLE)) begin
            errors++;
            $display("FAIL abort wrtdata %h state %0d want 25 0", wrtdata, dbgstate);
        end
        drain_scoreboard("abort");
    endtask

    task automatic test_unmapped();
        logic [7:0] rd;
        logic       oe;
        cfgrd = 8'hFF; ctrlrd = 8'hFF; wdogdivrd = 8'hFF;
        run_frame(16'h8500, 16, rd, oe);
        checks++;
        if (rd !== 8'h00) begin
            errors++;
            $display("FAIL read_addr5 miso got %h want 00", rd);
        end
        run_frame(16'h0511, 16, rd, oe);
        checks++;
        if (wrtdata !== 8'h25) begin
            errors++;
            $display("FAIL write_addr5 wrtdata got %h want 25", wrtdata);
        end
        drain_scoreboard("unmapped");
    endtask

    task automatic test_reset_midframe();
        logic [15:0] sh;
        logic [7:0]  rd;
        logic        m, oe;
        sh  = 16'h0180;
        csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            send_bit(sh[15], m);
            sh = {sh[14:0], 1'b0};
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({miso, misooe, wrtdata, cfgld, ctrlld, wdogdivld, ctrlrdce, dbgstate} !== 16'h0) begin
            errors++;
            $display("FAIL async_reset got %b want 0",
                     {miso, misooe, wrtdata, cfgld, ctrlld, wdogdivld, ctrlrdce, dbgstate});
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (HALF) @(negedge clk);
        csn = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        drain_scoreboard("reset_midframe");
        exp_q.push_back({K_CTRL, 8'h80});
        run_frame(16'h0180, 16, rd, oe);
        checks++;
        if (wrtdata !== 8'h80) begin
            errors++;
            $display("FAIL post_reset_write wrtdata got %h want 80", wrtdata);
        end
        drain_scoreboard("post_reset_write");
    endtask

    task automatic test_extra_pulses();
        logic [7:0] rd;
        logic       oe;
        exp_q.push_back({K_WDOG, 8'h07});
        run_frame(16'h0207, 20, rd, oe);
        checks++;
        if (wrtdata !== 8'h07) begin
            errors++;
            $display("FAIL extra_pulses wrtdata got %h want 07", wrtdata);
        end
        drain_scoreboard("extra_pulses");
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd, d;
        logic [2:0] a;
        logic       oe;
        d = 8'h00;
        for (int n = 0; n < 6; n++) begin
            a = 3'($urandom_range(0, 2));
            d = 8'($urandom_range(0, 255));
            exp_q.push_back({a, d});
            run_frame({5'b00000, a, d}, 16, rd, oe);
        end
        checks++;
        if (wrtdata !== d) begin
            errors++;
            $display("FAIL back_to_back wrtdata got %h want %h", wrtdata, d);
        end
        drain_scoreboard("back_to_back");
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_readback();
        test_abort();
        test_unmapped();
        test_reset_midframe();
        test_extra_pulses();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
